// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state encoding and IMEM address width for loader and fetch stage
package imem_loader_pkg;
  localparam int IMEM_ADDR_W = 14;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;
endpackage

// File: rtl/imem_loader_pack.sv
// loader_pack: byte-lane counter, little-endian word packer and running XOR checksum
module loader_pack (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic        last_o,
  output logic [31:0] word_o,
  output logic [7:0]  csum_o
);
  logic [1:0]  lane_q, lane_d;
  logic [31:0] sr_q, sr_d;
  logic [7:0]  csum_q, csum_d;
  // bytes enter at the top and shift down, so the first byte lands in [7:0]
  assign word_o = {byte_i, sr_q[31:8]};
  assign last_o = en_i && lane_q == 2'd3;
  assign csum_o = csum_q;
  always_comb begin
    lane_d = clr_i ? 2'd0 : en_i ? lane_q + 2'd1 : lane_q;
    sr_d   = clr_i ? 32'd0 : en_i ? word_o : sr_q;
    csum_d = clr_i ? 8'd0 : en_i ? csum_q ^ byte_i : csum_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q <= 2'd0;
      sr_q   <= 32'd0;
      csum_q <= 8'd0;
    end else begin
      lane_q <= lane_d;
      sr_q   <= sr_d;
      csum_q <= csum_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader writing 32-bit words into IMEM and holding the CPU until a good checksum
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o
);
  state_t            state_q;
  logic              rx_ready_q, we_q, cpu_hold_q, done_q, err_q;
  logic [ADDR_W-1:0] idx_q, nm1_q, waddr_q;
  logic [31:0]       wdata_q, word;
  logic [7:0]        len_lo_q, csum;
  logic [15:0]       n;
  logic              acc, clr, last;
  assign acc = rx_valid_i && rx_ready_q;
  assign clr = start_i && (state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign n   = {rx_data_i, len_lo_q};
  loader_pack u_pack (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr),
    .en_i   (acc && state_q == S_DATA),
    .byte_i (rx_data_i),
    .last_o (last),
    .word_o (word),
    .csum_o (csum)
  );
  // rx_ready is registered from the next state, so streaming bytes see no bubbles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      nm1_q      <= '0;
      len_lo_q   <= 8'd0;
    end else begin
      we_q <= 1'b0;
      if (clr) begin
        state_q    <= S_LEN_LO;
        rx_ready_q <= 1'b1;
        cpu_hold_q <= 1'b1;
        done_q     <= 1'b0;
        err_q      <= 1'b0;
        idx_q      <= '0;
      end else if (acc) begin
        case (state_q)
          S_LEN_LO: begin
            len_lo_q <= rx_data_i;
            state_q  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            nm1_q <= ADDR_W'(n - 16'd1);
            if (n == 16'd0) state_q <= S_CHECK;
            else if (32'(n) <= MAX_WORDS) state_q <= S_DATA;
            else begin
              state_q    <= S_ERROR;
              rx_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end
          end
          S_DATA: begin
            if (last) begin
              we_q    <= 1'b1;
              waddr_q <= idx_q;
              wdata_q <= word;
              if (idx_q == nm1_q) state_q <= S_CHECK;
              else idx_q <= idx_q + 1'b1;
            end
          end
          S_CHECK: begin
            rx_ready_q <= 1'b0;
            if (rx_data_i == csum) begin
              state_q    <= S_DONE;
              cpu_hold_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign rx_ready_o = rx_ready_q;
  assign we_o       = we_q;
  assign waddr_o    = waddr_q;
  assign wdata_o    = wdata_q;
  assign cpu_hold_o = cpu_hold_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed sessions with a write scoreboard checked on every WE pulse
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  rx_data_i = 8'd0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o, we_o, cpu_hold_o, done_o, err_o;
  logic [13:0] waddr_o;
  logic [31:0] wdata_o;
  int          checks = 0;
  int          failures = 0;
  int          extra_we = 0;
  logic [7:0]  csum;
  logic [45:0] sb[$];
  logic [45:0] e;

  imem_loader dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .we_o       (we_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .cpu_hold_o (cpu_hold_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we_o) begin
      if (sb.size() == 0) extra_we++;
      else begin
        e = sb.pop_front();
        check("we_addr", 32'(waddr_o), 32'(e[45:32]));
        check("we_data", wdata_o, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int t = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk);
    while (!rx_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready_o) begin
      check("ready_timeout", 32'(rx_ready_o), 32'd1);
      rx_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1 rx_valid_i = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_len(input logic [15:0] n);
    send(n[7:0], 1'b0);
    send(n[15:8], 1'b0);
  endtask

  task automatic send_word(input logic [13:0] a, input logic [31:0] w, input bit gap);
    sb.push_back({a, w});
    for (int i = 0; i < 4; i++) begin
      csum ^= w[8*i +: 8];
      send(w[8*i +: 8], gap);
    end
  endtask

  task automatic settle_and_flush(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    check({tag, "_extra_we"}, 32'(extra_we), 32'd0);
  endtask

  task automatic check_status(input string tag, input bit d, input bit er, input bit h, input bit r);
    check({tag, "_done"}, 32'(done_o), 32'(d));
    check({tag, "_err"}, 32'(err_o), 32'(er));
    check({tag, "_hold"}, 32'(cpu_hold_o), 32'(h));
    check({tag, "_ready"}, 32'(rx_ready_o), 32'(r));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_status("reset", 1'b0, 1'b0, 1'b1, 1'b0);
    check("reset_we", 32'(we_o), 32'd0);
    check("reset_waddr", 32'(waddr_o), 32'd0);
    check("reset_wdata", wdata_o, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("idle_ready", 32'(rx_ready_o), 32'd0);

    // two-word good load; checksum is XOR of the eight data bytes
    csum = 8'd0;
    pulse_start();
    check("start_ready", 32'(rx_ready_o), 32'd1);
    send_len(16'd2);
    send_word(14'd0, 32'h0000_0013, 1'b0);
    send_word(14'd1, 32'h0010_0093, 1'b0);
    check("model_csum", 32'(csum), 32'h90);
    send(csum, 1'b0);
    settle_and_flush("good2");
    check_status("good2", 1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_wdata", wdata_o, 32'h0010_0093);
    check("hold_waddr", 32'(waddr_o), 32'd1);

    // same stream with a wrong checksum byte
    csum = 8'd0;
    pulse_start();
    check_status("restart", 1'b0, 1'b0, 1'b1, 1'b1);
    send_len(16'd2);
    send_word(14'd0, 32'h0000_0013, 1'b0);
    send_word(14'd1, 32'h0010_0093, 1'b0);
    send(8'h81, 1'b0);
    settle_and_flush("badcs");
    check_status("badcs", 1'b0, 1'b1, 1'b1, 1'b0);

    // oversize length aborts right after LEN_HI
    pulse_start();
    send_len(16'h4001);
    settle_and_flush("oversize");
    check_status("oversize", 1'b0, 1'b1, 1'b1, 1'b0);

    // one word with RX_VALID gaps
    csum = 8'd0;
    pulse_start();
    send(8'h01, 1'b1);
    send(8'h00, 1'b1);
    send_word(14'd0, 32'hCAFE_F00D, 1'b1);
    send(csum, 1'b1);
    settle_and_flush("gapped");
    check_status("gapped", 1'b1, 1'b0, 1'b0, 1'b0);

    // reset mid-word, then a full session must start from a clean lane
    pulse_start();
    send_len(16'd1);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_status("midrst", 1'b0, 1'b0, 1'b1, 1'b0);
    check("midrst_we", 32'(we_o), 32'd0);
    check("midrst_wdata", wdata_o, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    csum = 8'd0;
    pulse_start();
    send_len(16'd1);
    send_word(14'd0, 32'h1234_5678, 1'b0);
    send(csum, 1'b0);
    settle_and_flush("afterrst");
    check_status("afterrst", 1'b1, 1'b0, 1'b0, 1'b0);

    // empty program, then reload of one word
    pulse_start();
    send_len(16'd0);
    send(8'h00, 1'b0);
    settle_and_flush("empty");
    check_status("empty", 1'b1, 1'b0, 1'b0, 1'b0);
    csum = 8'd0;
    pulse_start();
    check_status("reload_start", 1'b0, 1'b0, 1'b1, 1'b1);
    send_len(16'd1);
    send_word(14'd0, 32'h0000_006F, 1'b0);
    send(csum, 1'b0);
    settle_and_flush("reload");
    check_status("reload", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
